ysyx_23060332_wbu: RTL and testbench
====================================

Name: ysyx_23060332_wbu

Overview:
- Writeback unit: the write-side driver of the register file's single write port.
- Accepts results from EXU (ALU) and LSU (load) over valid/ready handshakes. Arbitrates them, formats load data, and registers one write per cycle onto waddr/wdata/reg_wen.
- Keeps a per-register busy scoreboard and gives IDU a stall signal for RAW/WAW hazards against in-flight writes.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NREG, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  IDU issues an instruction this cycle
- issue_wen  in  1  issued instruction writes a destination register
- issue_rd  in  ADDR_W  destination of issued instruction
- raddr1  in  ADDR_W  IDU source register 1
- raddr2  in  ADDR_W  IDU source register 2
- stall  out  1  IDU must hold; combinational
- exu_valid  in  1  EXU result valid
- exu_ready  out  1  WBU accepts EXU result
- exu_rd  in  ADDR_W  EXU destination
- exu_data  in  DATA_W  EXU result
- lsu_valid  in  1  LSU load result valid
- lsu_ready  out  1  WBU accepts LSU result
- lsu_rd  in  ADDR_W  load destination
- lsu_data  in  DATA_W  raw aligned memory word
- lsu_size  in  2  0 byte, 1 half, 2/3 word
- lsu_signed  in  1  1 = sign-extend, 0 = zero-extend
- lsu_addr_lo  in  2  byte offset of load address
- waddr  out  ADDR_W  register file write address (registered)
- wdata  out  DATA_W  register file write data (registered)
- reg_wen  out  1  register file write enable (registered)

Behaviour:
- Reset (synchronous, active-high; clock clk): waddr=0, wdata=0, reg_wen=0, hold buffer empty, all busy bits 0. Reset mid-transfer drops any held result and all busy state; the outputs take their reset values on the next edge.
- Handshake: a transfer completes on a posedge with valid && ready. Valid, once raised, is held with stable payload until accepted; the WBU does not check this.
- Hold buffer: 1 entry (rd, data) for the EXU result that loses arbitration.
- Ready signals: exu_ready = lsu_ready = !hold_valid. Both are combinational and independent of the valid inputs.
- Write source priority per cycle:
  - hold_valid: hold entry is written, then the buffer empties. EXU and LSU are not ready.
  - else lsu_valid: LSU result is written. If exu_valid too, the EXU result is captured into hold that same edge.
  - else exu_valid: EXU result is written.
  - else: reg_wen=0 next cycle. waddr/wdata hold their last value.
- Latency: the accepted result appears on waddr/wdata/reg_wen on the next cycle, exactly one cycle later. Sustained throughput is one write per cycle.
- rd==0: the result is consumed normally (handshake completes), but reg_wen=0 for that slot.
- Load formatting, using the byte lane:
  - byte: lane = lsu_addr_lo, width 8.
  - half: lane = lsu_addr_lo[1] (upper or lower 16 bits); lsu_addr_lo[0] is ignored.
  - word: lsu_data passes through.
  - Extension is sign or zero per lsu_signed; it does not apply to words.
- Scoreboard busy[NREG]:
  - Set on issue_valid && issue_wen && issue_rd!=0 && !stall.
  - Clear busy[waddr] on the posedge where reg_wen==1, so the register file holds the data afterwards.
  - If set and clear hit the same register on the same edge, set wins.
  - busy[0] is always 0.
- stall = issue_valid && ((raddr1!=0 && busy[raddr1]) || (raddr2!=0 && busy[raddr2]) || (issue_wen && issue_rd!=0 && busy[issue_rd])).
  - There is no bypass; the WAW term guarantees at most one in-flight write per register.

Decomposition:
- Shared define header (existing): RegAddrBus, RegDataBus widths, and the load size encodings LSU_B=0, LSU_H=1, LSU_W=2.
- One sub-module, ysyx_23060332_wbu_ldfmt: combinational load byte/half select plus extension.
- Arbitration, hold buffer, output register and scoreboard live in the top module.

Test Plan:
- Single EXU write: exu_valid, rd=5, data=0x1234 -> next cycle reg_wen=1, waddr=5, wdata=0x1234. busy[5] set at issue clears after that edge.
- Collision: LSU rd=3 word 0xDEADBEEF and EXU rd=4 0x11 in the same cycle -> cycle+1 writes r3; cycle+2 writes r4 from hold. Ready signals are low during cycle+1.
- Load formatting with lsu_data=0x80FF7F01:
  - byte, offset 3, signed -> 0xFFFFFF80.
  - half, offset 2, unsigned -> 0x000080FF.
  - byte, offset 1, signed -> 0x0000007F.
- rd=0 load: handshake completes, reg_wen stays 0, no busy change.
- Hazard: issue rd=7, then next cycle issue with raddr1=7 -> stall=1 until the cycle after reg_wen=1 with waddr=7.
  - A WAW issue to rd=7 while busy also stalls.
  - Issue to rd=7 on the same edge as its clear -> busy stays 1.
- Reset during collision: rst asserted with hold full -> next cycle reg_wen=0, hold empty, ready=1, all busy bits 0.

Source files
------------

// File: rtl/ysyx_23060332_wbu_pkg.sv
// Shared writeback definitions: register bus widths, load size encodings and
// the lane extension helper used by the load formatter.
package ysyx_23060332_wbu_pkg;

  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegDataBus = 32;

  localparam logic [1:0] LSU_B = 2'd0;
  localparam logic [1:0] LSU_H = 2'd1;
  localparam logic [1:0] LSU_W = 2'd2;

  // Widen an 8- or 16-bit lane (right-aligned in i_v) to a full register.
  function automatic logic [RegDataBus-1:0] lane_ext(input logic [15:0] i_v,
                                                     input logic        i_half,
                                                     input logic        i_sgn);
    logic [RegDataBus-1:0] r;
    if (i_half) r = {{(RegDataBus - 16){i_sgn & i_v[15]}}, i_v};
    else        r = {{(RegDataBus - 8){i_sgn & i_v[7]}}, i_v[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/ysyx_23060332_wbu_ldfmt.sv
// Load formatter: selects the addressed byte/half of an aligned memory word
// and sign- or zero-extends it; words pass through untouched.
module ysyx_23060332_wbu_ldfmt
  import ysyx_23060332_wbu_pkg::*;
(
  input  logic [RegDataBus-1:0] i_data,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [1:0]            i_addr_lo,
  output logic [RegDataBus-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    unique case (i_addr_lo)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
    // Halfword lane comes from addr bit 1 only; bit 0 is ignored.
    w_half = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];

    case (i_size)
      LSU_B:   o_data = lane_ext({8'h00, w_byte}, 1'b0, i_signed);
      LSU_H:   o_data = lane_ext(w_half, 1'b1, i_signed);
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// Writeback unit: arbitrates EXU/LSU results onto the register file write
// port, buffers a losing EXU result, and tracks busy registers for IDU stalls.
module ysyx_23060332_wbu
  import ysyx_23060332_wbu_pkg::*;
#(
  parameter int unsigned ADDR_W = RegAddrBus,
  parameter int unsigned DATA_W = RegDataBus,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              stall,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic [1:0]        lsu_size,
  input  logic              lsu_signed,
  input  logic [1:0]        lsu_addr_lo,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              reg_wen
);

  logic              r_hold_valid;
  logic [ADDR_W-1:0] r_hold_rd;
  logic [DATA_W-1:0] r_hold_data;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_d;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_set;

  ysyx_23060332_wbu_ldfmt u_ldfmt (
    .i_data    (lsu_data),
    .i_size    (lsu_size),
    .i_signed  (lsu_signed),
    .i_addr_lo (lsu_addr_lo),
    .o_data    (w_ld_data)
  );

  assign exu_ready = !r_hold_valid;
  assign lsu_ready = !r_hold_valid;

  // No bypass: any read of, or second write to, an in-flight register waits.
  assign stall = issue_valid &&
                 ((raddr1 != '0 && r_busy[raddr1]) ||
                  (raddr2 != '0 && r_busy[raddr2]) ||
                  (issue_wen && issue_rd != '0 && r_busy[issue_rd]));

  assign w_set = issue_valid && issue_wen && issue_rd != '0 && !stall;

  always_comb begin
    w_busy_d = r_busy;
    if (reg_wen) w_busy_d[waddr] = 1'b0;
    if (w_set)   w_busy_d[issue_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_rd    <= '0;
      r_hold_data  <= '0;
      r_busy       <= '0;
      waddr        <= '0;
      wdata        <= '0;
      reg_wen      <= 1'b0;
    end else begin
      r_busy <= w_busy_d;
      if (r_hold_valid) begin
        waddr        <= r_hold_rd;
        wdata        <= r_hold_data;
        reg_wen      <= r_hold_rd != '0;
        r_hold_valid <= 1'b0;
      end else if (lsu_valid) begin
        waddr   <= lsu_rd;
        wdata   <= w_ld_data;
        reg_wen <= lsu_rd != '0;
        // Losing EXU result is still accepted; park it for the next slot.
        if (exu_valid) begin
          r_hold_valid <= 1'b1;
          r_hold_rd    <= exu_rd;
          r_hold_data  <= exu_data;
        end
      end else if (exu_valid) begin
        waddr   <= exu_rd;
        wdata   <= exu_data;
        reg_wen <= exu_rd != '0;
      end else begin
        reg_wen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Scoreboard bench for the writeback unit: a stimulus process predicts writes
// and stalls from a queue-based model; a negedge monitor checks the write port.
module tb_ysyx_23060332_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 0, issue_wen = 0;
  logic [4:0]  issue_rd = 0, raddr1 = 0, raddr2 = 0;
  logic        stall;
  logic        exu_valid = 0, exu_ready;
  logic [4:0]  exu_rd = 0;
  logic [31:0] exu_data = 0;
  logic        lsu_valid = 0, lsu_ready;
  logic [4:0]  lsu_rd = 0;
  logic [31:0] lsu_data = 0;
  logic [1:0]  lsu_size = 0, lsu_addr_lo = 0;
  logic        lsu_signed = 0;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        reg_wen;

  ysyx_23060332_wbu dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .raddr1(raddr1), .raddr2(raddr2), .stall(stall),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_size(lsu_size), .lsu_signed(lsu_signed), .lsu_addr_lo(lsu_addr_lo),
    .waddr(waddr), .wdata(wdata), .reg_wen(reg_wen)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;

  // Reference state: pending buffered result, busy registers, write now visible.
  bit          m_hold;
  logic [4:0]  m_hold_rd;
  logic [31:0] m_hold_data;
  bit          m_busy[32];
  bit          m_prev_wen;
  logic [4:0]  m_prev_rd;
  logic        ae, al;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [1:0] sz,
                                      input logic sg, input logic [1:0] lo);
    logic [31:0] v;
    if (sz >= 2) return d;
    if (sz == 0) begin
      v = (d >> (8 * int'(lo))) & 32'hFF;
      if (sg && v > 127) v = v - 32'd256;
    end else begin
      v = (d >> (16 * int'(lo[1]))) & 32'hFFFF;
      if (sg && v > 32767) v = v - 32'd65536;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_write: rd %0d data %h never seen", q[0].rd, q[0].data);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        check("reg_wen", 32'(reg_wen), 32'd1);
        check("waddr", 32'(waddr), 32'(q[0].rd));
        check("wdata", wdata, q[0].data);
        void'(q.pop_front());
      end else begin
        check("reg_wen_idle", 32'(reg_wen), 32'd0);
      end
    end
  end

  task automatic step(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic [1:0] lsz, input logic lsg, input logic [1:0] llo,
                      input logic iv, input logic iw, input logic [4:0] ird,
                      input logic [4:0] ra1, input logic [4:0] ra2,
                      output logic acc_e, output logic acc_l);
    logic        exp_stall, got;
    logic [4:0]  wr;
    logic [31:0] wd;
    @(negedge clk);
    #1;
    exu_valid = ev; exu_rd = er; exu_data = ed;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    lsu_size = lsz; lsu_signed = lsg; lsu_addr_lo = llo;
    issue_valid = iv; issue_wen = iw; issue_rd = ird; raddr1 = ra1; raddr2 = ra2;
    #1;
    exp_stall = iv && ((ra1 != 0 && m_busy[ra1]) || (ra2 != 0 && m_busy[ra2]) ||
                       (iw && ird != 0 && m_busy[ird]));
    check("stall", 32'(stall), 32'(exp_stall));
    check("exu_ready", 32'(exu_ready), 32'(!m_hold));
    check("lsu_ready", 32'(lsu_ready), 32'(!m_hold));
    acc_e = ev && !m_hold;
    acc_l = lv && !m_hold;
    got = 0; wr = 0; wd = 0;
    if (m_hold) begin
      wr = m_hold_rd; wd = m_hold_data; got = 1; m_hold = 0;
    end else if (lv) begin
      wr = lr; wd = fmt(ld, lsz, lsg, llo); got = 1;
      if (ev) begin m_hold = 1; m_hold_rd = er; m_hold_data = ed; end
    end else if (ev) begin
      wr = er; wd = ed; got = 1;
    end
    if (m_prev_wen) m_busy[m_prev_rd] = 0;
    if (iv && iw && ird != 0 && !exp_stall) m_busy[ird] = 1;
    m_prev_wen = got && wr != 0;
    m_prev_rd  = wr;
    if (m_prev_wen) q.push_back('{cyc: cyc + 1, rd: wr, data: wd});
  endtask

  task automatic t_idle(input logic [4:0] probe);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, probe != 0, 0, 0, probe, 0, ae, al);
  endtask
  task automatic t_issue(input logic [4:0] rd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, rd, 0, 0, ae, al);
  endtask
  task automatic t_exu(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] probe);
    step(1, rd, d, 0, 0, 0, 0, 0, 0, probe != 0, 0, 0, probe, 0, ae, al);
  endtask
  task automatic t_lsu(input logic [4:0] rd, input logic [31:0] d, input logic [1:0] sz,
                       input logic sg, input logic [1:0] lo);
    step(0, 0, 0, 1, rd, d, sz, sg, lo, 0, 0, 0, 0, 0, ae, al);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1;
    exu_valid = 0; lsu_valid = 0; issue_valid = 0; issue_wen = 0;
    m_hold = 0; m_prev_wen = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    q.delete();
    @(negedge clk);
    #1;
    rst = 0;
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_reg_wen", 32'(reg_wen), 32'd0);
    check("rst_ready", 32'({exu_ready, lsu_ready}), 32'd3);
  endtask

  initial begin
    logic        pe, pl, ev, lv, iv, iw, lsg;
    logic [4:0]  er, lr, ird, ra1, ra2;
    logic [31:0] ed, ld;
    logic [1:0]  lsz, llo;

    repeat (2) @(negedge clk);
    do_reset();
    mon_en = 1;

    // Single EXU write with a busy dest; stall clears the cycle after the write.
    t_issue(5);
    t_exu(5, 32'h1234, 5);
    t_idle(5);
    t_idle(5);
    // LSU/EXU collision: EXU result drains from the buffer one cycle later.
    step(1, 4, 32'h11, 1, 3, 32'hDEADBEEF, 2, 0, 0, 0, 0, 0, 0, 0, ae, al);
    t_idle(0);
    t_idle(0);
    // Load formatting lanes.
    t_lsu(10, 32'h80FF7F01, 0, 1, 3);
    t_lsu(11, 32'h80FF7F01, 1, 0, 2);
    t_lsu(12, 32'h80FF7F01, 0, 1, 1);
    t_lsu(13, 32'h80FF7F01, 1, 1, 3);
    t_lsu(0,  32'h80FF7F01, 2, 0, 0);
    t_idle(0);
    // RAW and WAW hazards on r7.
    t_issue(7);
    t_idle(7);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, ae, al);
    t_exu(7, 32'h77, 7);
    t_idle(7);
    t_idle(7);
    // Issue to r7 on the same edge its unrelated write clears it: stays busy.
    t_exu(7, 32'h99, 0);
    t_issue(7);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7, ae, al);
    t_exu(7, 32'hAA, 0);
    t_idle(0);
    t_idle(7);
    // Reset with the hold buffer full and a busy register.
    t_issue(9);
    step(1, 4, 32'h22, 1, 3, 32'h5, 2, 0, 0, 0, 0, 0, 0, 0, ae, al);
    do_reset();
    t_idle(9);

    pe = 0; pl = 0;
    ev = 0; er = 0; ed = 0; lv = 0; lr = 0; ld = 0; lsz = 0; lsg = 0; llo = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pe && $urandom_range(1, 0) == 1) begin
        pe = 1; er = 5'($urandom_range(7, 0)); ed = $urandom;
      end
      if (!pl && $urandom_range(1, 0) == 1) begin
        pl = 1; lr = 5'($urandom_range(7, 0)); ld = $urandom;
        lsz = 2'($urandom_range(3, 0)); lsg = 1'($urandom_range(1, 0));
        llo = 2'($urandom_range(3, 0));
      end
      ev = pe; lv = pl;
      iv  = 1'($urandom_range(1, 0));
      iw  = 1'($urandom_range(1, 0));
      ird = 5'($urandom_range(7, 0));
      ra1 = 5'($urandom_range(7, 0));
      ra2 = 5'($urandom_range(7, 0));
      step(ev, er, ed, lv, lr, ld, lsz, lsg, llo, iv, iw, ird, ra1, ra2, ae, al);
      if (ae) pe = 0;
      if (al) pl = 0;
    end
    repeat (4) t_idle(0);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
